// File: rtl/datatrans_ctrl_pkg.sv
// Shared types and defaults for the burst transfer sequencer.
// State encoding is fixed so it can be observed on debug taps.
package datatrans_ctrl_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/xfer_down_cnt.sv
// Loadable down counter for the remaining word count.
// Clear beats load beats decrement; decrement saturates at zero.
module xfer_down_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_clr,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // counter register with priority clear / load / decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_dec && !o_zero)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/datatrans_ctrl.sv
// Single-burst word mover between a source FIFO port and a sink.
// Strobes are Mealy; status flags come from registered state.
module datatrans_ctrl
  import datatrans_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] data_num,
  input  logic             abort,
  input  logic             src_empty,
  input  logic [WIDTH-1:0] src_data,
  input  logic             dst_full,
  output logic             src_rd,
  output logic             dst_wr,
  output logic [WIDTH-1:0] dst_data,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] remaining
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_num;
  logic             r_aborted;
  logic             w_load;
  logic             w_clr;
  logic             w_xfer;
  logic             w_abort_hit;
  logic             w_zero;
  logic             w_take;

  assign w_take = (r_state == S_IDLE) && start;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // latch the word count alongside the accepted command
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_num <= '0;
    else if (w_take)
      r_num <= data_num;
  end

  // one-cycle abort pulse flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_aborted <= 1'b0;
    else
      r_aborted <= w_abort_hit;
  end

  // next-state and counter control decode
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_xfer      = 1'b0;
    w_abort_hit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = (data_num == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          w_next      = S_IDLE;
          w_clr       = 1'b1;
          w_abort_hit = 1'b1;
        end else begin
          w_load = 1'b1;
          w_next = S_XFER;
        end
      end
      S_XFER: begin
        if (abort) begin
          w_next      = S_IDLE;
          w_clr       = 1'b1;
          w_abort_hit = 1'b1;
        end else if (!src_empty && !dst_full && !w_zero) begin
          w_xfer = 1'b1;
          if (remaining == CNT_W'(1))
            w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  xfer_down_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_load_val(r_num),
    .i_clr     (w_clr),
    .i_dec     (w_xfer),
    .o_cnt     (remaining),
    .o_zero    (w_zero)
  );

  assign src_rd   = w_xfer;
  assign dst_wr   = w_xfer;
  assign dst_data = w_xfer ? src_data : '0;
  assign busy     = (r_state == S_LOAD) || (r_state == S_XFER);
  assign done     = (r_state == S_DONE);
  assign aborted  = r_aborted;

endmodule

// File: tb/tb_datatrans_ctrl.sv
// Scoreboard bench for the burst transfer sequencer.
// Words are queued at command time and popped on each push.
module tb_datatrans_ctrl;
  import datatrans_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] data_num;
  logic       abort;
  logic       src_empty;
  logic [7:0] src_data;
  logic       dst_full;
  logic       src_rd;
  logic       dst_wr;
  logic [7:0] dst_data;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [4:0] remaining;

  int errs   = 0;
  int checks = 0;
  int widx;

  logic [7:0] exp_q[$];

  state_t     ms;
  logic [4:0] mcnt;
  logic [4:0] mnum;
  logic       mab;

  datatrans_ctrl #(
    .WIDTH(8),
    .CNT_W(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_num (data_num),
    .abort    (abort),
    .src_empty(src_empty),
    .src_data (src_data),
    .dst_full (dst_full),
    .src_rd   (src_rd),
    .dst_wr   (dst_wr),
    .dst_data (dst_data),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic run(input int n, input int st_lo, input int st_hi,
                     input int ab_c, input int s2_c, input int ncyc,
                     output int strb, output int done_c,
                     output int ab_seen);
    logic ex;
    logic nab;
    strb    = 0;
    done_c  = -1;
    ab_seen = -1;
    widx    = 0;
    for (int i = 0; i < n; i++)
      exp_q.push_back(8'hA0 + 8'(i));
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start     = (c == 0) || (c == s2_c);
      data_num  = (c == 0) ? 5'(n) : 5'd9;
      abort     = (c == ab_c);
      dst_full  = (c >= st_lo) && (c <= st_hi);
      src_empty = 1'b0;
      src_data  = 8'hA0 + 8'(widx);
      @(negedge clk);
      ex = (ms == S_XFER) && !src_empty && !dst_full && !abort;
      chk("src_rd", src_rd, ex);
      chk("dst_wr", dst_wr, ex);
      chk("busy", busy, (ms == S_LOAD) || (ms == S_XFER));
      chk("done", done, ms == S_DONE);
      chk("aborted", aborted, mab);
      chk("remaining", remaining, mcnt);
      if (dst_wr) begin
        strb++;
        widx++;
        if (exp_q.size() == 0)
          chk("dst_wr_extra", dst_wr, 0);
        else
          chk("dst_data", dst_data, exp_q.pop_front());
      end else begin
        chk("dst_data_idle", dst_data, 0);
      end
      if (done)
        done_c = c;
      if (aborted)
        ab_seen = c;
      nab = abort && ((ms == S_LOAD) || (ms == S_XFER));
      case (ms)
        S_IDLE: if (start) begin
          mnum = data_num;
          ms   = (data_num == 0) ? S_DONE : S_LOAD;
        end
        S_LOAD: if (abort) begin
          ms   = S_IDLE;
          mcnt = 0;
        end else begin
          mcnt = mnum;
          ms   = S_XFER;
        end
        S_XFER: if (abort) begin
          ms   = S_IDLE;
          mcnt = 0;
        end else if (ex) begin
          if (mcnt == 1)
            ms = S_DONE;
          mcnt = mcnt - 1;
        end
        S_DONE: ms = S_IDLE;
        default: ms = S_IDLE;
      endcase
      mab = nab;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_src_rd"}, src_rd, 0);
    chk({tag, "_dst_wr"}, dst_wr, 0);
    chk({tag, "_dst_data"}, dst_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_remaining"}, remaining, 0);
  endtask

  initial begin
    int s, d, a;
    rst       = 1'b1;
    start     = 1'b0;
    data_num  = '0;
    abort     = 1'b0;
    src_empty = 1'b1;
    src_data  = '0;
    dst_full  = 1'b0;
    ms        = S_IDLE;
    mcnt      = '0;
    mnum      = '0;
    mab       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run(4, -1, -1, -1, 6, 9, s, d, a);
    chk("basic_strobes", s, 4);
    chk("basic_done_cyc", d, 6);
    chk("basic_no_abort", a, -1);

    run(3, 3, 4, -1, -1, 9, s, d, a);
    chk("stall_strobes", s, 3);
    chk("stall_done_cyc", d, 7);

    run(0, -1, -1, -1, -1, 4, s, d, a);
    chk("zero_strobes", s, 0);
    chk("zero_done_cyc", d, 1);

    run(8, -1, -1, 4, -1, 8, s, d, a);
    chk("abort_strobes", s, 2);
    chk("abort_pulse_cyc", a, 5);
    chk("abort_no_done", d, -1);
    chk("abort_left", exp_q.size(), 6);
    exp_q.delete();

    run(5, -1, -1, -1, 3, 9, s, d, a);
    chk("busy_start_strobes", s, 5);
    chk("busy_start_done", d, 7);

    run(6, -1, -1, -1, -1, 4, s, d, a);
    @(posedge clk);
    #1;
    start     = 1'b0;
    abort     = 1'b0;
    dst_full  = 1'b0;
    src_empty = 1'b0;
    chk("pre_rst_rd", src_rd, 1);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    ms   = S_IDLE;
    mcnt = '0;
    mab  = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_done", done, 0);
    chk("midrst_aborted", aborted, 0);
    rst = 1'b0;

    run(6, -1, -1, -1, -1, 10, s, d, a);
    chk("post_rst_strobes", s, 6);
    chk("post_rst_done", d, 8);

    run(31, -1, -1, -1, -1, 36, s, d, a);
    chk("max_strobes", s, 31);
    chk("max_done_cyc", d, 33);
    chk("max_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
